// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP with memory handshakes.
// Optional memory-wait timeout enabled by defining MEMCTRL_TIMEOUT_EN.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    input  logic                 branch_taken,
    output logic                 imem_req,
    output logic                 ir_load,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [1:0]           alu_src_a,
    output logic                 alu_src_b,
    output logic                 wrt_en,
    output logic [1:0]           wb_sel,
    output logic                 pc_en,
    output logic [1:0]           pc_sel,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_RSV6   = 3'd6,
        S_RSV7   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_FENCE
    } cls_t;

    state_t                 state_reg, state_next;
    cls_t                   cls_reg, dec_cls;
    logic                   dec_legal;
    logic                   illegal_reg;
    logic [INSTRET_W-1:0]   instret_reg;

    logic       imem_req_c, ir_load_c, dmem_req_c, dmem_we_c;
    logic [1:0] alu_src_a_c, wb_sel_c, pc_sel_c;
    logic       alu_src_b_c, wrt_en_c, pc_en_c;
    logic       timeout_hit;

    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_R;
        case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_IALU;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b0001111: dec_cls = C_FENCE;
            default:    dec_legal = 1'b0;
        endcase
    end

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;

    // Counts consecutive un-acked request cycles; any other cycle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == S_FETCH && !imem_ack) ||
                     (state_reg == S_MEM && !dmem_ack)) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        imem_req_c  = 1'b0;
        ir_load_c   = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        alu_src_a_c = 2'd0;
        alu_src_b_c = 1'b0;
        wrt_en_c    = 1'b0;
        wb_sel_c    = 2'd0;
        pc_en_c     = 1'b0;
        pc_sel_c    = 2'd0;
        case (state_reg)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_load_c  = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: state_next = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                state_next = S_WB;
                case (cls_reg)
                    C_IALU:  alu_src_b_c = 1'b1;
                    C_LOAD, C_STORE: begin
                        alu_src_b_c = 1'b1;
                        state_next  = S_MEM;
                    end
                    C_LUI: begin
                        alu_src_a_c = 2'd2;
                        alu_src_b_c = 1'b1;
                    end
                    C_AUIPC: begin
                        alu_src_a_c = 2'd1;
                        alu_src_b_c = 1'b1;
                    end
                    C_BRANCH: begin
                        pc_en_c    = 1'b1;
                        pc_sel_c   = branch_taken ? 2'd1 : 2'd0;
                        state_next = S_FETCH;
                    end
                    C_FENCE: begin
                        pc_en_c    = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_reg == C_STORE);
                if (dmem_ack) begin
                    if (cls_reg == C_STORE) begin
                        pc_en_c    = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                wrt_en_c   = 1'b1;
                pc_en_c    = 1'b1;
                wb_sel_c   = (cls_reg == C_LOAD) ? 2'd1 :
                             (cls_reg == C_JAL || cls_reg == C_JALR) ? 2'd2 : 2'd0;
                pc_sel_c   = (cls_reg == C_JAL) ? 2'd2 :
                             (cls_reg == C_JALR) ? 2'd3 : 2'd0;
                state_next = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            cls_reg     <= C_R;
            illegal_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                cls_reg <= dec_cls;
            if (state_next == S_TRAP)
                illegal_reg <= 1'b1;
            if (pc_en_c)
                instret_reg <= instret_reg + INSTRET_W'(1);
        end
    end

    // While reset is held every strobe and select reads as zero.
    assign imem_req  = imem_req_c & ~rst;
    assign ir_load   = ir_load_c & ~rst;
    assign dmem_req  = dmem_req_c & ~rst;
    assign dmem_we   = dmem_we_c & ~rst;
    assign alu_src_a = rst ? 2'd0 : alu_src_a_c;
    assign alu_src_b = alu_src_b_c & ~rst;
    assign wrt_en    = wrt_en_c & ~rst;
    assign wb_sel    = rst ? 2'd0 : wb_sel_c;
    assign pc_en     = pc_en_c & ~rst;
    assign pc_sel    = rst ? 2'd0 : pc_sel_c;
    assign state     = state_reg;
    assign illegal   = illegal_reg;
    assign instret   = instret_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are queued with stimulus.
// Define MEMCTRL_TIMEOUT_EN for both bench and DUT to exercise the timeout path.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst, imem_ack, dmem_ack, branch_taken;
    logic [6:0]  opcode;
    logic        imem_req, ir_load, dmem_req, dmem_we, alu_src_b, wrt_en, pc_en, illegal;
    logic [1:0]  alu_src_a, wb_sel, pc_sel;
    logic [2:0]  state;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .INSTRET_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .imem_req(imem_req), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .wrt_en(wrt_en), .wb_sel(wb_sel), .pc_en(pc_en), .pc_sel(pc_sel), .state(state),
        .illegal(illegal), .instret(instret)
    );

    localparam int EW = 49;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
        OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
        OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_FENCE = 7'b0001111;

    logic [EW-1:0] exp_q[$];
    logic [4:0]    stim_q[$];   // {skip, rst, imem_ack, dmem_ack, branch_taken}
    string         tag_q[$];
    int            nerr = 0, nchk = 0;
    logic          mdl_ill;
    logic [31:0]   mdl_instret;

    function automatic logic [EW-1:0] observed();
        return {state, imem_req, ir_load, dmem_req, dmem_we, alu_src_a, alu_src_b,
                wrt_en, wb_sel, pc_en, pc_sel, illegal, instret};
    endfunction

    // req = {imem_req, ir_load, dmem_req, dmem_we}; stim = {rst, imem_ack, dmem_ack, taken}
    task automatic push_cyc(input string tag, input logic [3:0] stim, input logic [2:0] st,
                            input logic [3:0] req, input logic [1:0] a, input logic b,
                            input logic we, input logic [1:0] wbs, input logic pe,
                            input logic [1:0] ps, input bit skip = 1'b0);
        exp_q.push_back({st, req, a, b, we, wbs, pe, ps, mdl_ill, mdl_instret});
        stim_q.push_back({skip, stim});
        tag_q.push_back(tag);
        if (pe) mdl_instret = mdl_instret + 32'd1;
    endtask

    task automatic flush();
        logic [EW-1:0] e;
        logic [4:0]    s;
        string         t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            t = tag_q.pop_front();
            rst = s[3]; imem_ack = s[2]; dmem_ack = s[1]; branch_taken = s[0];
            @(negedge clk);
            if (!s[4]) begin
                nchk++;
                assert (observed() === e) else begin
                    nerr++;
                    $error("FAIL %s: observed=%h expected=%h", t, observed(), e);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        push_cyc({tag, ":rst0"}, 4'b1000, state, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        mdl_ill = 1'b0;
        mdl_instret = 32'd0;
        push_cyc({tag, ":rst1"}, 4'b1000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        flush();
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input int iw,
                             input int dw, input logic taken);
        logic [1:0] a, wbs, ps;
        logic       b, pe, to_mem, to_wb;
        int         n;
        n = exp_q.size();
        opcode = op;
        for (int i = 0; i < iw; i++)
            push_cyc({tag, ":fwait"}, 4'b0000, 3'd0, 4'b1000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        push_cyc({tag, ":fetch"}, 4'b0100, 3'd0, 4'b1100, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        if (!(op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE})) begin
            push_cyc({tag, ":decode"}, 4'b0000, 3'd1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
            mdl_ill = 1'b1;
            for (int i = 0; i < 20; i++)
                push_cyc({tag, ":trap"}, 4'b0111, 3'd5, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
            n = exp_q.size() - n;
            flush();
            $display("instr %s op=%b cycles=%0d instret=%0d illegal=%0d", tag, op, n, instret, illegal);
            return;
        end
        push_cyc({tag, ":decode"}, 4'b0000, 3'd1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        a = 2'd0; b = 1'b0; pe = 1'b0; ps = 2'd0; to_mem = 1'b0; to_wb = 1'b1;
        case (op)
            OP_I:        b = 1'b1;
            OP_LD, OP_ST: begin b = 1'b1; to_mem = 1'b1; to_wb = 1'b0; end
            OP_LUI:      begin a = 2'd2; b = 1'b1; end
            OP_AUIPC:    begin a = 2'd1; b = 1'b1; end
            OP_BR:       begin pe = 1'b1; ps = taken ? 2'd1 : 2'd0; to_wb = 1'b0; end
            OP_FENCE:    begin pe = 1'b1; to_wb = 1'b0; end
            default: ;
        endcase
        push_cyc({tag, ":exec"}, {3'b000, taken}, 3'd2, 4'b0000, a, b, 1'b0, 2'd0, pe, ps);
        if (to_mem) begin
            for (int i = 0; i < dw; i++)
                push_cyc({tag, ":mwait"}, 4'b0000, 3'd3, {3'b001, op == OP_ST}, 2'd0, 1'b0,
                         1'b0, 2'd0, 1'b0, 2'd0);
            push_cyc({tag, ":mem"}, 4'b0010, 3'd3, {3'b001, op == OP_ST}, 2'd0, 1'b0,
                     1'b0, 2'd0, op == OP_ST, 2'd0);
            to_wb = (op == OP_LD);
        end
        if (to_wb) begin
            wbs = (op == OP_LD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
            ps  = (op == OP_JAL) ? 2'd2 : (op == OP_JALR) ? 2'd3 : 2'd0;
            push_cyc({tag, ":wb"}, 4'b0000, 3'd4, 4'b0000, 2'd0, 1'b0, 1'b1, wbs, 1'b1, ps);
        end
        n = exp_q.size() - n;
        flush();
        $display("instr %s op=%b cycles=%0d instret=%0d", tag, op, n, instret);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; opcode = OP_R;
        mdl_ill = 1'b0; mdl_instret = 32'd0;
        do_reset("reset");

        run_instr("addi", OP_I, 0, 0, 1'b0);
        run_instr("add", OP_R, 0, 0, 1'b0);
        run_instr("load", OP_LD, 0, 3, 1'b0);
        run_instr("branch_t", OP_BR, 0, 0, 1'b1);
        run_instr("branch_nt", OP_BR, 0, 0, 1'b0);
        run_instr("store", OP_ST, 0, 1, 1'b0);
        run_instr("jal", OP_JAL, 0, 0, 1'b0);
        run_instr("jalr", OP_JALR, 0, 0, 1'b0);
        run_instr("lui", OP_LUI, 0, 0, 1'b0);
        run_instr("auipc", OP_AUIPC, 0, 0, 1'b0);
        run_instr("fence", OP_FENCE, 1, 0, 1'b0);
        run_instr("load_fast", OP_LD, 2, 0, 1'b0);

`ifdef MEMCTRL_TIMEOUT_EN
        opcode = OP_R;
        for (int i = 0; i < 4; i++)
            push_cyc("timeout:fwait", 4'b0000, 3'd0, 4'b1000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        mdl_ill = 1'b1;
        for (int i = 0; i < 2; i++)
            push_cyc("timeout:trap", 4'b0000, 3'd5, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        flush();
        $display("instr timeout op=%b instret=%0d illegal=%0d", opcode, instret, illegal);
        do_reset("timeout");
`else
        run_instr("long_fetch", OP_R, 6, 0, 1'b0);
`endif

        run_instr("illegal", 7'b1111111, 0, 0, 1'b0);
        do_reset("trap");

        // Reset lands while a store is waiting in MEM.
        opcode = OP_ST;
        push_cyc("st_rst:fetch", 4'b0100, 3'd0, 4'b1100, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        push_cyc("st_rst:decode", 4'b0000, 3'd1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        push_cyc("st_rst:exec", 4'b0000, 3'd2, 4'b0000, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
        push_cyc("st_rst:mwait", 4'b0000, 3'd3, 4'b0011, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        push_cyc("st_rst:mwait", 4'b0000, 3'd3, 4'b0011, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        flush();
        do_reset("st_rst");
        push_cyc("st_rst:release", 4'b0000, 3'd0, 4'b1000, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        flush();
        run_instr("after_rst", OP_I, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the instruction and data memory request handshakes. It also generates the control signals for the decode/ALU/register-file datapath and counts retired instructions. It sits in top, between the instruction register/decode outputs and the register file write port.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory request may wait for ack (used only with the optional feature)
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  ins[6:0] of the currently latched instruction
imem_ack  input  1  instruction memory ready; instruction valid this cycle
dmem_ack  input  1  data memory access complete this cycle
branch_taken  input  1  branch compare result from ALU, valid in EXEC
imem_req  output  1  instruction fetch request
ir_load  output  1  latch fetched word into instruction register
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
alu_src_a  output  2  0=rs1, 1=pc, 2=zero
alu_src_b  output  1  0=rs2, 1=imm
wrt_en  output  1  register file write enable
wb_sel  output  2  0=ALU result, 1=load data, 2=pc+4
pc_en  output  1  PC update strobe
pc_sel  output  2  0=pc+4, 1=branch target, 2=JAL target, 3=JALR target
state  output  3  current FSM state encoding
illegal  output  1  sticky trap flag
instret  output  INSTRET_W  retired instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH on the next cycle.
- Reset, sampled on a clk edge with rst=1:
  - state=FETCH, instret=0, illegal=0.
  - All strobes and requests are 0. Selects are 0.
  - Reset wins over any in-flight request, including mid-MEM: dmem_req drops the next cycle.
- FETCH:
  - imem_req=1, held until imem_ack.
  - In the ack cycle, ir_load=1 (one cycle) and next state is DECODE.
  - No ack: stay in FETCH.
- DECODE: classify opcode.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, 0001111 FENCE.
  - Any other opcode goes to TRAP.
- EXEC, per class:
  - R: alu_src_a=0, alu_src_b=0, next WB.
  - I-ALU, LOAD, STORE: alu_src_a=0, alu_src_b=1. I-ALU next WB; LOAD and STORE next MEM.
  - LUI: alu_src_a=2, alu_src_b=1, next WB.
  - AUIPC: alu_src_a=1, alu_src_b=1, next WB.
  - JAL, JALR: next WB.
  - BRANCH: alu_src_a=0, alu_src_b=0, pc_en=1, pc_sel = branch_taken ? 1 : 0. Next FETCH; this is a retire.
  - FENCE: pc_en=1, pc_sel=0, next FETCH; this is a retire.
- MEM:
  - dmem_req=1 and dmem_we=(STORE), held stable until dmem_ack.
  - STORE on ack: pc_en=1, pc_sel=0, next FETCH; this is a retire.
  - LOAD on ack: next WB.
- WB:
  - wrt_en=1 for exactly one cycle. It is asserted even when rd=x0; the register file ignores x0 writes.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_en=1 in the same cycle; pc_sel: 2 for JAL, 3 for JALR, else 0.
  - Next FETCH; this is a retire.
- Retire: instret += 1 in the cycle pc_en=1. Wraps modulo 2^INSTRET_W.
- Latency with zero-wait acks, in cycles:
  - BRANCH and FENCE: 3.
  - R, I-ALU, LUI, AUIPC, JAL, JALR, STORE: 4.
  - LOAD: 5.
- TRAP: illegal=1, all strobes 0, instret frozen. Leaves only on rst.
- Outputs not listed for a state are 0 in that state. Requests and selects are registered-state decodes (Moore style), except ir_load, pc_en/pc_sel in MEM, and the MEM-to-next transition, which depend on the ack.

Optional Feature:
MEMCTRL_TIMEOUT_EN:
- Defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - If it reaches TIMEOUT_CYCLES without an ack, the FSM enters TRAP and illegal=1; requests drop the next cycle.
  - An ack arriving in the same cycle as the limit is reached wins.
- Undefined: waits are unbounded and no counter logic is synthesized.

Test Plan:
- rst=1 for 2 cycles, then 0 with imem_ack=1, ins=0x00700093 (addi x1,x0,7) -> state 0,1,2,4,0; ir_load in cycle 0; alu_src_b=1 in EXEC; wrt_en=1 and wb_sel=0 only in cycle 3; instret 0->1.
- ins=0x002081B3 (add x3,x1,x2) -> alu_src_a=0 and alu_src_b=0 in EXEC; 4-cycle retire; instret increments by 1.
- LOAD opcode 0000011 with dmem_ack arriving 3 cycles after MEM entry -> dmem_req=1 for 4 cycles with dmem_we=0; then WB with wb_sel=1 and one wrt_en pulse; 8 cycles total.
- BRANCH with branch_taken=1, then with 0 -> pc_en in EXEC with pc_sel=1, then pc_sel=0; no wrt_en; 3 cycles each.
- ins=0xFFFFFFFF -> TRAP on the cycle after DECODE; illegal=1; instret unchanged for 20 cycles; rst=1 returns state to 0 with illegal=0.
- rst asserted during a STORE in MEM with dmem_ack=0 -> next cycle state=0 and dmem_req=0. With MEMCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=4, imem_ack held 0 -> TRAP after 4 FETCH cycles.
